// File: rtl/rtc_preset_arbiter_pkg.sv
// Shared types for the RTC preset arbiter: packed time word, FSM states, calendar helper.
package rtc_preset_arbiter_pkg;

  localparam int RTC_TIME_W   = 44;
  localparam int RTC_DEF_YEAR = 2000;

  typedef struct packed {
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  dom;
    logic [2:0]  dow;
    logic [1:0]  mode;
    logic [5:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
  } rtc_time_t;

  typedef enum logic [1:0] {IDLE, LOAD, ACK, HOLD} state_t;

  // Gregorian rule restricted to the counter's range: 2100 is the only century year reachable.
  function automatic logic [4:0] max_day(input logic [3:0] month, input logic [11:0] year);
    case (month)
      4'd2:                     max_day = (year[1:0] == 2'b00 && year != 12'd2100) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  max_day = 5'd30;
      default:                  max_day = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_preset_arbiter_if.sv
// Requester-side handshake bundle of the RTC preset arbiter (requests, time words, ack/nack).
interface rtc_preset_arbiter_if
  import rtc_preset_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            req_clr_i;
  logic [NUM_REQ*RTC_TIME_W-1:0] req_time_i;
  logic [NUM_REQ-1:0]            ack_o;
  logic                          nack_o;

  modport master (output req_i, req_clr_i, req_time_i, input ack_o, nack_o);
  modport slave  (input req_i, req_clr_i, req_time_i, output ack_o, nack_o);
endinterface

// File: rtl/rtc_preset_arbiter_validator.sv
// Combinational range check of a time word; built only with RTC_PRESET_VALIDATE_EN defined.
`ifdef RTC_PRESET_VALIDATE_EN
module rtc_time_validator
  import rtc_preset_arbiter_pkg::*;
(
  input  rtc_time_t time_i,
  output logic      valid_o
);
  logic hour_ok;
  logic unused_mode;

  assign unused_mode = time_i.mode[1];

  // mode[0] selects 12-hour clock, where hour runs 1..12
  assign hour_ok = time_i.mode[0] ? (time_i.hour >= 6'd1 && time_i.hour <= 6'd12)
                                  : (time_i.hour < 6'd24);

  assign valid_o = (time_i.sec < 6'd60) && (time_i.min < 6'd60) && hour_ok &&
                   (time_i.dow >= 3'd1) &&
                   (time_i.month >= 4'd1) && (time_i.month <= 4'd12) &&
                   (time_i.dom >= 5'd1) && (time_i.dom <= max_day(time_i.month, time_i.year));
endmodule
`endif

// File: rtl/rtc_preset_arbiter.sv
// Round-robin arbiter feeding the RTC counter preset port with one-cycle load strobes.
// Optional time-word range check enabled by defining RTC_PRESET_VALIDATE_EN.
module rtc_preset_arbiter
  import rtc_preset_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int HOLDOFF_CYC = 1
)(
  input  logic                 clk_1Hz_i,
  input  logic                 rstn_i,
  rtc_preset_arbiter_if.slave  rq,
  output logic                 enable_o,
  output logic                 en_preset_o,
  output rtc_time_t            init_time_o,
  output logic                 busy_o
);

  localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] HOLD_LAST = (HOLDOFF_CYC > 0) ? 4'(HOLDOFF_CYC - 1) : 4'd0;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, win_q, win_d, win_sel, cand;
  logic [3:0]         hold_cnt_q;
  logic               found, sel_clr, reject;
  rtc_time_t          sel_time;

  logic               enable_d, en_preset_d, busy_d, nack_d;
  logic [NUM_REQ-1:0] ack_d;
  rtc_time_t          init_time_d;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    wrap_idx = IDX_W'(v % NUM_REQ);
  endfunction

  // first requester at or after rr_ptr, wrapping at NUM_REQ
  always_comb begin
    found = 1'b0;
    win_d = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(int'(rr_ptr_q) + i);
      if (!found && rq.req_i[cand]) begin
        found = 1'b1;
        win_d = cand;
      end
    end
  end

  assign sel_time = rtc_time_t'(rq.req_time_i[win_d*RTC_TIME_W +: RTC_TIME_W]);
  assign sel_clr  = rq.req_clr_i[win_d];

`ifdef RTC_PRESET_VALIDATE_EN
  logic sel_valid;
  rtc_time_validator u_validator (
    .time_i  (sel_time),
    .valid_o (sel_valid)
  );
  assign reject = !sel_clr && !sel_valid;
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found)
        win_q <= win_d;
      if (state_q == ACK)
        rr_ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      hold_cnt_q <= (state_q == HOLD) ? hold_cnt_q + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = reject ? ACK : LOAD;
      LOAD:    state_d = ACK;
      ACK:     state_d = (HOLDOFF_CYC > 0) ? HOLD : IDLE;
      HOLD:    if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs are the registered image of the state being entered
  always_comb begin
    win_sel     = (state_q == IDLE) ? win_d : win_q;
    enable_d    = (state_d == LOAD);
    en_preset_d = (state_d == LOAD) && !sel_clr;
    ack_d       = (state_d == ACK) ? (NUM_REQ'(1) << win_sel) : '0;
    nack_d      = (state_q == IDLE) && (state_d == ACK);
    busy_d      = (state_d != IDLE);
    init_time_d = init_time_o;
    if (state_q == IDLE && state_d == LOAD)
      init_time_d = sel_clr ? '0 : sel_time;
  end

  always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      enable_o    <= 1'b0;
      en_preset_o <= 1'b0;
      init_time_o <= '0;
      rq.ack_o    <= '0;
      rq.nack_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      enable_o    <= enable_d;
      en_preset_o <= en_preset_d;
      init_time_o <= init_time_d;
      rq.ack_o    <= ack_d;
      rq.nack_o   <= nack_d;
      busy_o      <= busy_d;
    end
  end

endmodule
